// File: rtl/cas_seq_divider_pkg.sv
// cas_seq_divider_pkg: shared width, iteration-counter width and FSM state type for the divider
package cas_seq_divider_pkg;
  localparam int N = 4;
  localparam int CNT_W = $clog2(N);
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_e;
endpackage

// File: rtl/cas_seq_divider_cas.sv
// cas_step: one controlled add/subtract row (a_i -/+ m_i per sub_i), q_bit_o = ~sign of result
module cas_step
  import cas_seq_divider_pkg::*;
(
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] m_i,
  input  logic         sub_i,
  output logic [N-1:0] a_new_o,
  output logic         q_bit_o
);
  always_comb begin
    a_new_o = sub_i ? a_i - m_i : a_i + m_i;
    q_bit_o = ~a_new_o[N-1];
  end
endmodule

// File: rtl/cas_seq_divider.sv
// cas_seq_divider: sequential non-restoring divider (start/dividend/divisor in; busy, out_valid, quo, a_raw, m_out, err out)
module cas_seq_divider
  import cas_seq_divider_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         out_valid,
  output logic [N-1:0] quo,
  output logic [N-1:0] a_raw,
  output logic [N-1:0] m_out,
  output logic         err
);
  state_e state_q, state_d;
  logic [N-1:0] a_q, a_d, q_q, q_d, m_q, m_d, a_new;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic err_q, err_d, q_bit, bad;
  cas_step u_step (
    .a_i    ({a_q[N-2:0], q_q[N-1]}),
    .m_i    (m_q),
    .sub_i  (~a_q[N-1]),
    .a_new_o(a_new),
    .q_bit_o(q_bit)
  );
  assign bad = (divisor == '0) || divisor[N-1];
  // the error path goes straight to DONE, so busy only covers a real iteration run
  assign busy = (state_q == ITER) || (state_q == DONE && !err_q);
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    q_d = q_q;
    m_d = m_q;
    cnt_d = cnt_q;
    err_d = err_q;
    case (state_q)
      IDLE: if (start) begin
        a_d = '0;
        q_d = bad ? '0 : dividend;
        m_d = divisor;
        cnt_d = '0;
        err_d = bad;
        state_d = bad ? DONE : ITER;
      end
      ITER: begin
        a_d = a_new;
        q_d = {q_q[N-2:0], q_bit};
        cnt_d = cnt_q + 1'b1;
        state_d = (cnt_q == CNT_W'(N-1)) ? DONE : ITER;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      out_valid <= 1'b0;
      quo <= '0;
      a_raw <= '0;
      m_out <= '0;
      err <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      q_q <= q_d;
      m_q <= m_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      // results are published on the edge leaving DONE and then held until the next result
      out_valid <= (state_q == DONE);
      if (state_q == DONE) begin
        quo <= q_q;
        a_raw <= a_q;
        m_out <= m_q;
        err <= err_q;
      end
    end
  end
endmodule

// File: tb/tb_cas_seq_divider.sv
// tb_cas_seq_divider: directed self-checking bench for cas_seq_divider
module tb_cas_seq_divider;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [3:0] dividend = '0, divisor = '0;
  logic busy, out_valid, err;
  logic [3:0] quo, a_raw, m_out;
  int n_vec = 0, n_fail = 0;
  cas_seq_divider dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .out_valid(out_valid), .quo(quo), .a_raw(a_raw), .m_out(m_out), .err(err)
  );
  always #5 clk = ~clk;
  task automatic do_start(input logic [3:0] dv, input logic [3:0] ds);
    @(negedge clk);
    start = 1'b1;
    dividend = dv;
    divisor = ds;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 4'hF;
    divisor = 4'h1;
  endtask
  task automatic wait_valid(output int lat, output bit b_any, output bit b_all);
    lat = 0;
    b_any = 0;
    b_all = 1;
    while (!out_valid && lat < 20) begin
      b_any |= busy;
      b_all &= busy;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask
  task automatic test_reset;
    #1;
    n_vec++;
    if ({busy, out_valid, quo, a_raw, m_out, err} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h want 0", {busy, out_valid, quo, a_raw, m_out, err});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_divide;
    logic [3:0] tv [3][4] = '{'{4'd11, 4'd3, 4'b0011, 4'b0010},
                              '{4'd8,  4'd3, 4'b0010, 4'b1111},
                              '{4'd7,  4'd7, 4'b0001, 4'b0000}};
    int lat;
    bit b_any, b_all;
    for (int i = 0; i < 3; i++) begin
      do_start(tv[i][0], tv[i][1]);
      wait_valid(lat, b_any, b_all);
      n_vec++;
      if (lat !== 5) begin n_fail++; $display("FAIL div%0d_latency got %0d want 5", i, lat); end
      n_vec++;
      if (b_all !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL div%0d_busy got all=%0b at_valid=%0b want 1/0", i, b_all, busy);
      end
      n_vec++;
      if ({quo, a_raw, m_out, err} !== {tv[i][2], tv[i][3], tv[i][1], 1'b0}) begin
        n_fail++;
        $display("FAIL div%0d_result got q=%b a=%b m=%b e=%b want q=%b a=%b m=%b e=0",
                 i, quo, a_raw, m_out, err, tv[i][2], tv[i][3], tv[i][1]);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({out_valid, quo, a_raw} !== {1'b0, tv[i][2], tv[i][3]}) begin
        n_fail++;
        $display("FAIL div%0d_hold got v=%b q=%b a=%b want v=0 q=%b a=%b",
                 i, out_valid, quo, a_raw, tv[i][2], tv[i][3]);
      end
    end
  endtask
  task automatic test_error;
    logic [3:0] ds [2] = '{4'd0, 4'd8};
    int lat;
    bit b_any, b_all;
    for (int i = 0; i < 2; i++) begin
      do_start(4'd9, ds[i]);
      wait_valid(lat, b_any, b_all);
      n_vec++;
      if (lat !== 1) begin n_fail++; $display("FAIL err%0d_latency got %0d want 1", i, lat); end
      n_vec++;
      if ({b_any, busy} !== 2'b00) begin
        n_fail++;
        $display("FAIL err%0d_busy got %b want 00", i, {b_any, busy});
      end
      n_vec++;
      if ({err, quo, a_raw, m_out} !== {1'b1, 4'd0, 4'd0, ds[i]}) begin
        n_fail++;
        $display("FAIL err%0d_result got e=%b q=%b a=%b m=%b want e=1 q=0 a=0 m=%b",
                 i, err, quo, a_raw, m_out, ds[i]);
      end
    end
  endtask
  task automatic test_reset_mid;
    int lat, pulses;
    bit b_any, b_all;
    do_start(4'd11, 4'd3);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++;
    if ({busy, out_valid, quo, a_raw, m_out, err} !== 15'd0) begin
      n_fail++;
      $display("FAIL midrst_outputs got %h want 0", {busy, out_valid, quo, a_raw, m_out, err});
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      pulses += int'(out_valid);
    end
    n_vec++;
    if (pulses !== 0) begin n_fail++; $display("FAIL midrst_no_valid got %0d pulses want 0", pulses); end
    do_start(4'd11, 4'd3);
    wait_valid(lat, b_any, b_all);
    n_vec++;
    if ({lat == 5, quo, a_raw} !== {1'b1, 4'b0011, 4'b0010}) begin
      n_fail++;
      $display("FAIL midrst_restart got lat=%0d q=%b a=%b want lat=5 q=0011 a=0010", lat, quo, a_raw);
    end
  endtask
  task automatic test_back_to_back;
    int pulses = 0;
    logic [3:0] q_seen = '0, a_seen = '0, m_seen = '0;
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd11;
    divisor = 4'd3;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      dividend = 4'(i + 4);
      divisor = 4'(7 - i);
      @(posedge clk);
      #1;
      if (out_valid) begin
        pulses++;
        q_seen = quo;
        a_seen = a_raw;
        m_seen = m_out;
      end
    end
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      pulses += int'(out_valid);
    end
    n_vec++;
    if (pulses !== 1) begin n_fail++; $display("FAIL b2b_pulses got %0d want 1", pulses); end
    n_vec++;
    if ({q_seen, a_seen, m_seen} !== {4'b0011, 4'b0010, 4'd3}) begin
      n_fail++;
      $display("FAIL b2b_result got q=%b a=%b m=%b want q=0011 a=0010 m=0011", q_seen, a_seen, m_seen);
    end
  endtask
  initial begin
    test_reset;
    test_divide;
    test_error;
    test_reset_mid;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
